banked_ram: RTL and testbench
=============================

# banked_ram

Multi-port, multi-bank synchronous RAM with per-byte write enables and a valid/grant request handshake. Requesters are arbitrated per bank. Reads return data after a parametrised fixed latency. It succeeds the single-port RAM as the shared scratchpad between the RISC-V core and the accelerator datapaths. Concurrent accesses to different banks complete in the same cycle. Accesses that conflict on a bank are serialised fairly.

## Interface
- DATA_WIDTH, 32: word width in bits.
- RAM_DEPTH, 512: total words; power of two, divisible by NUM_BANKS.
- NUM_PORTS, 2: requester count, 1..8.
- NUM_BANKS, 2: bank count, power of two, 1..8.
- RD_LATENCY, 1: read latency in cycles after grant; 1 or 2.
- Derived: ADDR_WIDTH = clog2(RAM_DEPTH), WREN_WIDTH = ceil(DATA_WIDTH/8), BANK_BITS = clog2(NUM_BANKS).
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- reqIn  in  NUM_PORTS  per-port request valid.
- addrIn  in  NUM_PORTS*ADDR_WIDTH  per-port word address; port p occupies slice p.
- wrEnIn  in  NUM_PORTS*WREN_WIDTH  per-port byte mask; nonzero means write, zero means read.
- wrDataIn  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- gntOut  out  NUM_PORTS  combinational grant; the request is accepted at the clock edge where reqIn and gntOut are both high.
- rdAckOut  out  NUM_PORTS  one-cycle read-data-valid pulse.
- rdDataOut  out  NUM_PORTS*DATA_WIDTH  per-port read data; valid only while rdAckOut is high.

## Operation
- Bank = addr[BANK_BITS-1:0]; row = addr[ADDR_WIDTH-1:BANK_BITS]. Consecutive words interleave across banks.
- Each bank performs at most one access per cycle. Each bank has its own round-robin arbiter over the ports targeting it.
- Arbiter pointer:
  - Reset value 0.
  - After a grant, it moves to winner+1 mod NUM_PORTS.
  - With no grant, it holds.
  - Priority starts at the pointer index.
- A requester holds reqIn, addrIn, wrEnIn and wrDataIn stable until granted. Withdrawing a request before grant is legal and has no side effect.
- A granted write updates only the bytes whose mask bit is set. No ack is generated for a write.
- A granted read produces exactly one rdAckOut pulse on its own port, RD_LATENCY cycles later.
- A port may be granted on back-to-back cycles. Acks return in grant order, so there is no reordering per port.
- Ordering across ports follows grant order. A read granted after a write to the same address returns the new data. Same-bank same-cycle collisions cannot occur because only one access is granted per bank per cycle.
- Memory contents are not initialised and are not cleared by rst.

## Timing
- Grant is combinational from reqIn, addrIn and the arbiter pointers, in the same cycle.
- RD_LATENCY=1: rdAckOut/rdDataOut are registered from the bank array, valid in the cycle after the grant edge.
- RD_LATENCY=2: an extra output register is added, and the ack arrives one cycle later.
- Throughput: up to min(NUM_PORTS, NUM_BANKS) accesses per cycle.
- Reset values:
  - rdAckOut = 0, rdDataOut = 0.
  - Arbiter pointers = 0.
  - Read pipeline valid bits = 0.
  - gntOut = 0 while rst is high, regardless of reqIn.
- Reset mid-operation: in-flight reads are dropped with no ack. Writes granted on the edge where rst is sampled high are not performed.
- rdDataOut holds its last value when rdAckOut is low; it is not required to be zero.

## Structure
- Shared package ram_pkg:
  - clog2-style width helpers.
  - Constants RD_LAT_MIN=1 and RD_LAT_MAX=2.
  - Bank/row field extraction functions, reused by other RAM variants.
- Sub-module rr_arbiter: parametrised on NUM_PORTS; inputs request vector and advance enable; outputs one-hot grant. Instantiated once per bank.
- Top-level contents:
  - Request-to-bank decode.
  - Bank arrays, inferred with byte-enable writes.
  - Per-port read pipeline carrying valid plus bank index.
  - Output mux.

## Test plan
- Single write then read: defaults, port 0 writes 0xDEADBEEF to addr 0x005 with mask 0xF, then reads 0x005 → rdAckOut[0] pulses one cycle after the read grant with data 0xDEADBEEF.
- Byte enables: write 0xFFFFFFFF to addr 0x010, then write 0x00000000 with mask 0x5, then read → 0xFF00FF00.
- Bank conflict and fairness: ports 0 and 1 both hold read requests to bank 0 (addrs 0x000, 0x002) for 4 cycles → grants alternate 0,1,0,1; exactly one grant per cycle.
- Parallel banks: port 0 reads 0x004 and port 1 reads 0x007 in the same cycle → both granted that cycle; both acks arrive together with the correct data.
- RD_LATENCY=2, back-to-back: port 0 reads 0x001, 0x003 and 0x005 on consecutive cycles → three acks on consecutive cycles, starting two cycles after the first grant, in address order.
- Reset mid-flight: assert rst for one cycle immediately after a read grant → no rdAckOut pulse; after release, pointers are 0 and port 0 wins the first conflict.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared helpers for the RAM family: width arithmetic, latency limits and
// address field extraction for bank-interleaved layouts.
package ram_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Index width that never collapses to zero, so a one-entry dimension still has a legal vector.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bytes_of(input int bits);
    return (bits + 7) / 8;
  endfunction

  function automatic logic [31:0] bank_of(input logic [31:0] addr, input int bank_bits);
    return addr & ((32'd1 << bank_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] row_of(input logic [31:0] addr, input int bank_bits);
    return addr >> bank_bits;
  endfunction

endpackage

// File: rtl/banked_ram_if.sv
// Request/response bundle between requesters and the banked scratchpad; each
// vector carries one slice per port.
interface banked_ram_if
  import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 512,
    parameter int NUM_PORTS  = 2
) ();

    localparam int ADDR_WIDTH = width_of(RAM_DEPTH);
    localparam int WREN_WIDTH = bytes_of(DATA_WIDTH);

    logic [NUM_PORTS-1:0]            reqIn;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addrIn;
    logic [NUM_PORTS*WREN_WIDTH-1:0] wrEnIn;
    logic [NUM_PORTS*DATA_WIDTH-1:0] wrDataIn;
    logic [NUM_PORTS-1:0]            gntOut;
    logic [NUM_PORTS-1:0]            rdAckOut;
    logic [NUM_PORTS*DATA_WIDTH-1:0] rdDataOut;

    modport master (
        output reqIn, addrIn, wrEnIn, wrDataIn,
        input  gntOut, rdAckOut, rdDataOut
    );

    modport slave (
        input  reqIn, addrIn, wrEnIn, wrDataIn,
        output gntOut, rdAckOut, rdDataOut
    );

endinterface

// File: rtl/banked_ram_rr_arbiter.sv
// Round-robin arbiter: priority starts at the pointer, and the pointer moves
// one past the winner whenever a grant is taken.
module rr_arbiter
  import ram_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 adv,
    output logic [NUM_PORTS-1:0] gnt
);

    localparam int PTR_W = width_of(NUM_PORTS);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;

    // NOTE: every output of a combinational block gets a default first; otherwise paths that skip an assignment infer latches.
    always_comb begin
        gnt    = '0;
        winner = ptr;
        // Walk offsets from farthest to nearest so the requester closest to the pointer wins last.
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(ptr) + i) % NUM_PORTS;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                winner   = PTR_W'(idx);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (adv && |req) begin
            ptr <= PTR_W'((int'(winner) + 1) % NUM_PORTS);
        end
    end

endmodule

// File: rtl/banked_ram.sv
// Multi-port, word-interleaved banked scratchpad with per-bank round-robin
// arbitration, byte-masked writes and fixed-latency read returns.
module banked_ram
  import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 512,
    parameter int NUM_PORTS  = 2,
    parameter int NUM_BANKS  = 2,
    parameter int RD_LATENCY = 1
) (
    input logic          clk,
    input logic          rst,
    banked_ram_if.slave  bus
);

    localparam int ADDR_WIDTH = width_of(RAM_DEPTH);
    localparam int WREN_WIDTH = bytes_of(DATA_WIDTH);
    localparam int BANK_BITS  = $clog2(NUM_BANKS);
    localparam int BANK_W     = width_of(NUM_BANKS);
    localparam int ROW_DEPTH  = RAM_DEPTH / NUM_BANKS;
    localparam int ROW_W      = width_of(ROW_DEPTH);
    localparam int PAD_W      = WREN_WIDTH * 8;

    logic [BANK_W-1:0]    port_bank [NUM_PORTS];
    logic [ROW_W-1:0]     port_row  [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt_b     [NUM_BANKS];
    logic [PAD_W-1:0]     bank_rd   [NUM_BANKS];
    logic [NUM_PORTS-1:0] gnt_any;
    logic [NUM_PORTS-1:0] rd_gnt;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            logic [ADDR_WIDTH-1:0] a;
            a            = bus.addrIn[p*ADDR_WIDTH +: ADDR_WIDTH];
            port_bank[p] = BANK_W'(bank_of(32'(a), BANK_BITS));
            port_row[p]  = ROW_W'(row_of(32'(a), BANK_BITS));
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [NUM_PORTS-1:0]  req_b;
        logic                  sel_valid;
        logic [ROW_W-1:0]      sel_row;
        logic [WREN_WIDTH-1:0] sel_wen;
        logic [PAD_W-1:0]      sel_wdata;
        logic [PAD_W-1:0]      mem [ROW_DEPTH];
        logic [PAD_W-1:0]      rd_q;

        always_comb begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                req_b[p] = bus.reqIn[p] && (port_bank[p] == BANK_W'(b));
            end
        end

        rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
            .clk (clk),
            .rst (rst),
            .req (req_b),
            .adv (~rst),
            .gnt (gnt_b[b])
        );

        always_comb begin
            sel_valid = 1'b0;
            sel_row   = '0;
            sel_wen   = '0;
            sel_wdata = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (gnt_b[b][p] && !rst) begin
                    sel_valid = 1'b1;
                    sel_row   = port_row[p];
                    sel_wen   = bus.wrEnIn[p*WREN_WIDTH +: WREN_WIDTH];
                    sel_wdata = PAD_W'(bus.wrDataIn[p*DATA_WIDTH +: DATA_WIDTH]);
                end
            end
        end

        // NOTE: the array and its read register carry no reset so the bank maps onto block RAM.
        always_ff @(posedge clk) begin
            if (sel_valid) begin
                for (int i = 0; i < WREN_WIDTH; i++) begin
                    if (sel_wen[i]) mem[sel_row][i*8 +: 8] <= sel_wdata[i*8 +: 8];
                end
                if (sel_wen == '0) rd_q <= mem[sel_row];
            end
        end

        assign bank_rd[b] = rd_q;
    end

    always_comb begin
        gnt_any = '0;
        for (int b = 0; b < NUM_BANKS; b++) gnt_any = gnt_any | gnt_b[b];
        bus.gntOut = rst ? '0 : gnt_any;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_gnt[p] = bus.gntOut[p] && (bus.wrEnIn[p*WREN_WIDTH +: WREN_WIDTH] == '0);
        end
    end

    // Stage 1 remembers which bank's read register holds each port's data.
    logic [NUM_PORTS-1:0]            v1;
    logic [BANK_W-1:0]               b1 [NUM_PORTS];
    logic [NUM_PORTS*DATA_WIDTH-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (rst) v1 <= '0;
        else     v1 <= rd_gnt;
        for (int p = 0; p < NUM_PORTS; p++) b1[p] <= port_bank[p];
    end

    always_comb begin
        s1_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            s1_data[p*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(bank_rd[b1[p]]);
        end
    end

    if (RD_LATENCY <= RD_LAT_MIN) begin : g_lat1
        logic [NUM_PORTS*DATA_WIDTH-1:0] hold_q;
        logic [NUM_PORTS*DATA_WIDTH-1:0] data_c;

        always_comb begin
            data_c = hold_q;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (v1[p]) data_c[p*DATA_WIDTH +: DATA_WIDTH] = s1_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) hold_q <= '0;
            else     hold_q <= data_c;
        end

        assign bus.rdAckOut  = v1;
        assign bus.rdDataOut = data_c;
    end else begin : g_lat2
        logic [NUM_PORTS-1:0]            v2;
        logic [NUM_PORTS*DATA_WIDTH-1:0] d2;

        always_ff @(posedge clk) begin
            if (rst) begin
                v2 <= '0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (v1[p]) d2[p*DATA_WIDTH +: DATA_WIDTH] <= s1_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end

        assign bus.rdAckOut  = v2;
        assign bus.rdDataOut = d2;
    end

endmodule

// File: tb/tb_banked_ram.sv
// Drives latency-1 and latency-2 instances with identical traffic; a monitor
// scores read returns against a word-array reference model.
module tb_banked_ram;
    localparam int DW = 32, DEPTH = 512, NP = 2, NB = 2, AW = 9, WW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    banked_ram_if #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .NUM_PORTS(NP)) bus1 ();
    banked_ram_if #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .NUM_PORTS(NP)) bus2 ();

    banked_ram #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .NUM_PORTS(NP), .NUM_BANKS(NB), .RD_LATENCY(1))
        u_dut_lat1 (.clk(clk), .rst(rst), .bus(bus1));
    banked_ram #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .NUM_PORTS(NP), .NUM_BANKS(NB), .RD_LATENCY(2))
        u_dut_lat2 (.clk(clk), .rst(rst), .bus(bus2));

    logic [NP-1:0]    req_v = '0;
    logic [NP*AW-1:0] addr_v = '0;
    logic [NP*WW-1:0] wen_v = '0;
    logic [NP*DW-1:0] wdata_v = '0;

    assign bus1.reqIn = req_v;   assign bus2.reqIn = req_v;
    assign bus1.addrIn = addr_v; assign bus2.addrIn = addr_v;
    assign bus1.wrEnIn = wen_v;  assign bus2.wrEnIn = wen_v;
    assign bus1.wrDataIn = wdata_v; assign bus2.wrDataIn = wdata_v;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [DW-1:0] data; int due; } exp_t;
    exp_t            sb [2*NP][$];
    logic [DW-1:0]   ref_mem [int];
    int              ptr [NB];
    logic [NP-1:0]   last_gnt1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Each bank serves the first requester at or after its pointer.
    function automatic logic [NP-1:0] model_grant();
        logic [NP-1:0] g;
        g = '0;
        if (!rst) begin
            for (int b = 0; b < NB; b++) begin
                bit taken;
                taken = 0;
                for (int k = 0; k < NP; k++) begin
                    int p;
                    p = (ptr[b] + k) % NP;
                    if (!taken && req_v[p] && (int'(addr_v[p*AW +: AW]) % NB == b)) begin
                        g[p]  = 1'b1;
                        taken = 1;
                    end
                end
            end
        end
        return g;
    endfunction

    task automatic apply(input logic [NP-1:0] g);
        for (int p = 0; p < NP; p++) begin
            if (g[p]) begin
                int            a;
                logic [WW-1:0] m;
                logic [DW-1:0] d;
                exp_t          e;
                a = int'(addr_v[p*AW +: AW]);
                m = wen_v[p*WW +: WW];
                d = wdata_v[p*DW +: DW];
                if (m != '0) begin
                    logic [DW-1:0] w;
                    w = ref_mem.exists(a) ? ref_mem[a] : '0;
                    for (int i = 0; i < WW; i++) if (m[i]) w[i*8 +: 8] = d[i*8 +: 8];
                    ref_mem[a] = w;
                end else begin
                    e.data = ref_mem[a];
                    e.due  = cyc + 1;
                    sb[p].push_back(e);
                    e.due  = cyc + 2;
                    sb[NP+p].push_back(e);
                end
                ptr[a % NB] = (p + 1) % NP;
            end
        end
    endtask

    task automatic step(output logic [NP-1:0] g);
        #1;
        g = model_grant();
        last_gnt1 = bus1.gntOut;
        check("gnt_lat1", 64'(bus1.gntOut), 64'(g));
        check("gnt_lat2", 64'(bus2.gntOut), 64'(g));
        if (rst) for (int b = 0; b < NB; b++) ptr[b] = 0;
        else     apply(g);
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic r, input logic [AW-1:0] a,
                            input logic [WW-1:0] m, input logic [DW-1:0] d);
        req_v[p]             = r;
        addr_v[p*AW +: AW]   = a;
        wen_v[p*WW +: WW]    = m;
        wdata_v[p*DW +: DW]  = d;
    endtask

    task automatic run_pending();
        logic [NP-1:0] g;
        int n;
        n = 0;
        while (req_v != '0 && n < 50) begin
            step(g);
            req_v = req_v & ~g;
            n++;
        end
        check("pending_drained", 64'(req_v), 64'd0);
    endtask

    // Monitor: score every port of both instances once per cycle.
    always begin
        @(negedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NP; p++) begin
                int            i;
                logic          ack;
                logic [DW-1:0] data;
                i    = d * NP + p;
                ack  = (d == 0) ? bus1.rdAckOut[p] : bus2.rdAckOut[p];
                data = (d == 0) ? bus1.rdDataOut[p*DW +: DW] : bus2.rdDataOut[p*DW +: DW];
                if (rst) begin
                    while (sb[i].size() > 0 && sb[i][$].due >= cyc) void'(sb[i].pop_back());
                end else if (sb[i].size() > 0 && sb[i][0].due == cyc) begin
                    check($sformatf("ack_lat%0d_p%0d", d + 1, p), 64'(ack), 64'd1);
                    if (ack) check($sformatf("rdata_lat%0d_p%0d", d + 1, p), 64'(data), 64'(sb[i][0].data));
                    void'(sb[i].pop_front());
                end else begin
                    check($sformatf("no_ack_lat%0d_p%0d", d + 1, p), 64'(ack), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NP-1:0] g;
        int left;
        for (int b = 0; b < NB; b++) ptr[b] = 0;
        @(negedge clk);

        // Requests during reset must not be granted.
        set_port(0, 1'b1, 9'h000, 4'h0, 32'h0);
        set_port(1, 1'b1, 9'h002, 4'h0, 32'h0);
        repeat (3) step(g);
        check("rst_ack_lat1", 64'(bus1.rdAckOut), 64'd0);
        check("rst_ack_lat2", 64'(bus2.rdAckOut), 64'd0);
        check("rst_data_lat1", 64'(bus1.rdDataOut), 64'd0);
        check("rst_data_lat2", 64'(bus2.rdDataOut), 64'd0);
        req_v = '0;
        rst   = 1'b0;
        step(g);

        // Fill the working window so every later read has known contents.
        for (int a = 0; a < 32; a += 2) begin
            set_port(0, 1'b1, AW'(a), 4'hF, $urandom());
            set_port(1, 1'b1, AW'(a + 1), 4'hF, $urandom());
            run_pending();
        end

        set_port(0, 1'b1, 9'h005, 4'hF, 32'hDEADBEEF); run_pending();
        set_port(0, 1'b1, 9'h005, 4'h0, 32'h0);        run_pending();

        set_port(0, 1'b1, 9'h010, 4'hF, 32'hFFFFFFFF); run_pending();
        set_port(0, 1'b1, 9'h010, 4'h5, 32'h00000000); run_pending();
        set_port(0, 1'b1, 9'h010, 4'h0, 32'h0);        run_pending();

        // Different banks proceed together.
        set_port(0, 1'b1, 9'h004, 4'h0, 32'h0);
        set_port(1, 1'b1, 9'h007, 4'h0, 32'h0);
        step(g);
        check("parallel_gnt", 64'(last_gnt1), 64'd3);
        req_v = '0;

        // Back-to-back reads from one port.
        for (int k = 0; k < 3; k++) begin
            set_port(0, 1'b1, AW'(2 * k + 1), 4'h0, 32'h0);
            step(g);
            check($sformatf("b2b_gnt_%0d", k), 64'(last_gnt1), 64'd1);
        end
        req_v = '0;
        repeat (3) step(g);

        // Reset straight after a read grant, then a held bank-0 conflict.
        set_port(0, 1'b1, 9'h009, 4'h0, 32'h0);
        step(g);
        check("midflight_gnt", 64'(last_gnt1), 64'd1);
        rst = 1'b1;
        set_port(0, 1'b1, 9'h000, 4'h0, 32'h0);
        set_port(1, 1'b1, 9'h002, 4'h0, 32'h0);
        step(g);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(g);
            check($sformatf("fair_gnt_%0d", k), 64'(last_gnt1), (k % 2 == 0) ? 64'd1 : 64'd2);
        end
        req_v = '0;
        step(g);

        // Random traffic with holds, withdrawals and bank conflicts.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!req_v[p]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        logic [WW-1:0] m;
                        m = ($urandom_range(0, 2) == 0) ? WW'($urandom_range(1, 15)) : '0;
                        set_port(p, 1'b1, AW'($urandom_range(0, 31)), m, $urandom());
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_v[p] = 1'b0;
                end
            end
            step(g);
            req_v = req_v & ~g;
        end

        req_v = '0;
        repeat (5) step(g);
        left = 0;
        for (int i = 0; i < 2 * NP; i++) left += sb[i].size();
        check("scoreboard_empty", 64'(left), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
